// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: write-port controller for the 3-read/1-write register file.
// Arbitrates ALU (req0) and load (req1) writebacks onto RW/PW/LE, keeps a
// pending-write scoreboard and flags read hazards for decode.
// Optional feature: define REGFILE_BYPASS_EN to forward PW to readers during the
// LE cycle instead of stalling them until the file write lands.
module regfile_wb_scheduler #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIXED_PRI = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [ADDR_W-1:0]      req0_rd,
    input  logic [DATA_W-1:0]      req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [ADDR_W-1:0]      req1_rd,
    input  logic [DATA_W-1:0]      req1_data,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_rd,
    output logic                   iss_ready,
    input  logic [ADDR_W-1:0]      ra,
    input  logic [ADDR_W-1:0]      rb,
    input  logic [ADDR_W-1:0]      rc,
    output logic                   haz_a,
    output logic                   haz_b,
    output logic                   haz_c,
    output logic [2:0]             fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [ADDR_W-1:0]      RW,
    output logic [DATA_W-1:0]      PW,
    output logic                   LE,
    output logic [2**ADDR_W-1:0]   pending
);

    localparam int NREGS = 2**ADDR_W;

    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] pw_q, pw_d;
    logic              le_q, le_d;
    logic [NREGS-1:0]  pending_q, pending_d;
    // rr_last_q = 1 means req1 won the previous tie, so req0 wins the next one
    logic              rr_last_q, rr_last_d;
    logic              gnt0, gnt1;

    // Grant selection; round-robin pointer only moves when both requesters compete
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rr_last_d = rr_last_q;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRI != 0) begin
                gnt1 = 1'b1;
            end else if (rr_last_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
            rr_last_d = gnt1;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Write-port next state: capture the granted request, suppress LE for r0
    always_comb begin
        rw_d = rw_q;
        pw_d = pw_q;
        le_d = 1'b0;
        if (gnt0) begin
            rw_d = req0_rd;
            pw_d = req0_data;
            le_d = (req0_rd != '0);
        end else if (gnt1) begin
            rw_d = req1_rd;
            pw_d = req1_data;
            le_d = (req1_rd != '0);
        end
    end

    // An instruction may only issue when no older write to its rd is outstanding
    assign iss_ready = ~pending_q[iss_rd];

    // Scoreboard: clear on the LE cycle, then set on issue so a same-edge set wins
    always_comb begin
        pending_d = pending_q;
        if (le_q) begin
            pending_d[rw_q] = 1'b0;
        end
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset drops any in-flight write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q      <= '0;
            pw_q      <= '0;
            le_q      <= 1'b0;
            pending_q <= '0;
            rr_last_q <= 1'b1;
        end else begin
            rw_q      <= rw_d;
            pw_q      <= pw_d;
            le_q      <= le_d;
            pending_q <= pending_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign RW      = rw_q;
    assign PW      = pw_q;
    assign LE      = le_q;
    assign pending = pending_q;

    // Per-read-select hazard and bypass detection
    logic [ADDR_W-1:0] sel [3];
    logic [2:0]        haz_v;
    logic [2:0]        fwd_v;

    assign sel[0] = ra;
    assign sel[1] = rb;
    assign sel[2] = rc;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            logic sel_nz;
            assign sel_nz = (sel[gi] != '0);
`ifdef REGFILE_BYPASS_EN
            // The value being written this cycle is already on PW, so serve it directly
            assign fwd_v[gi] = le_q && sel_nz && (sel[gi] == rw_q);
            assign haz_v[gi] = pending_q[sel[gi]] && sel_nz && !fwd_v[gi];
`else
            assign fwd_v[gi] = 1'b0;
            assign haz_v[gi] = pending_q[sel[gi]] && sel_nz;
`endif
        end
    endgenerate

    assign haz_a   = haz_v[0];
    assign haz_b   = haz_v[1];
    assign haz_c   = haz_v[2];
    assign fwd_hit = fwd_v;
`ifdef REGFILE_BYPASS_EN
    assign fwd_data = pw_q;
`else
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed stimulus, expected write-port
// transactions queued by the stimulus and checked by an independent monitor.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, iss_valid;
    logic [4:0]  req0_rd, req1_rd, iss_rd, ra, rb, rc;
    logic [31:0] req0_data, req1_data;

    logic        req0_ready, req1_ready, iss_ready, haz_a, haz_b, haz_c, LE;
    logic [2:0]  fwd_hit;
    logic [31:0] fwd_data, PW;
    logic [4:0]  RW;
    logic [31:0] pending;

    logic        fp_req0_ready, fp_req1_ready, fp_iss_ready, fp_haz_a, fp_haz_b, fp_haz_c, fp_le;
    logic [2:0]  fp_fwd_hit;
    logic [31:0] fp_fwd_data, fp_pw, fp_pending;
    logic [4:0]  fp_rw;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .FIXED_PRI(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .ra(ra), .rb(rb), .rc(rc), .haz_a(haz_a), .haz_b(haz_b), .haz_c(haz_c),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .RW(RW), .PW(PW), .LE(LE), .pending(pending)
    );

    regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(fp_iss_ready),
        .ra(ra), .rb(rb), .rc(rc), .haz_a(fp_haz_a), .haz_b(fp_haz_b), .haz_c(fp_haz_c),
        .fwd_hit(fp_fwd_hit), .fwd_data(fp_fwd_data), .RW(fp_rw), .PW(fp_pw), .LE(fp_le),
        .pending(fp_pending)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every LE cycle must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && LE) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_le: got RW=%0d PW=0x%0h expected no write", RW, PW);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_rw", 64'(RW), 64'(e.rd));
                chk("wb_pw", 64'(PW), 64'(e.data));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; iss_valid = 0;
        req0_rd = 0; req1_rd = 0; iss_rd = 0; ra = 0; rb = 0; rc = 0;
        req0_data = 0; req1_data = 0;
        step(); step();
        chk("rst_le", 64'(LE), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_rw_pw", {27'd0, RW, PW}, 64'd0);
        rst_n = 1'b1;
        step();

        // Single write to r5 with hazard tracking
        iss_valid = 1; iss_rd = 5;
        #1 chk("iss5_ready", 64'(iss_ready), 64'd1);
        step();
        iss_valid = 0; ra = 5;
        #1 chk("haz_a_r5_pending", 64'(haz_a), 64'd1);
        req0_valid = 1; req0_rd = 5; req0_data = 20;
        #1 chk("req0_ready_single", 64'(req0_ready), 64'd1);
        push(5, 20);
        step();
        req0_valid = 0;
        #1 chk("pending5_in_le", 64'(pending[5]), 64'd1);
`ifdef REGFILE_BYPASS_EN
        chk("haz_a_le_bypass", 64'(haz_a), 64'd0);
`else
        chk("haz_a_le_nobypass", 64'(haz_a), 64'd1);
`endif
        step();
        #1 chk("pending5_cleared", 64'(pending[5]), 64'd0);
        chk("haz_a_cleared", 64'(haz_a), 64'd0);
        chk("le_after_write", 64'(LE), 64'd0);
        ra = 0;

        // Mid-stream reset: tie won by req0 flips rr pointer, then reset drops the write
        iss_valid = 1; iss_rd = 9;
        req0_valid = 1; req0_rd = 3; req0_data = 32'h33;
        req1_valid = 1; req1_rd = 4; req1_data = 32'h44;
        #1 chk("tie_pre_rst_r0", {req0_ready, req1_ready}, 64'b10);
        step();
        iss_valid = 0; req0_valid = 0; req1_valid = 0;
        #1 rst_n = 1'b0;
        #1 chk("midrst_le", 64'(LE), 64'd0);
        chk("midrst_pending", 64'(pending), 64'd0);
        chk("midrst_rw_pw", {27'd0, RW, PW}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Tie held four cycles: grants alternate starting with req0
        req0_valid = 1; req0_rd = 1; req0_data = 21;
        req1_valid = 1; req1_rd = 2; req1_data = 22;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("tie_grant_req0", {req0_ready, req1_ready}, 64'b10);
                push(1, 21);
            end else begin
                chk("tie_grant_req1", {req0_ready, req1_ready}, 64'b01);
                push(2, 22);
            end
            chk("fixed_pri_grant", {fp_req0_ready, fp_req1_ready}, 64'b01);
            step();
        end
        req0_valid = 0; req1_valid = 0;
        step();
        #1 chk("tie_pending_clean", 64'(pending), 64'd0);

        // Writes and issues targeting r0
        req0_valid = 1; req0_rd = 0; req0_data = 99;
        #1 chk("r0_ready", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 0;
        iss_valid = 1; iss_rd = 0; ra = 0;
        #1 chk("r0_no_le", 64'(LE), 64'd0);
        chk("iss_r0_ready", 64'(iss_ready), 64'd1);
        chk("ra0_no_haz", 64'(haz_a), 64'd0);
        step();
        iss_valid = 0;
        #1 chk("r0_pending_unchanged", 64'(pending), 64'd0);

        // WAW on r30
        iss_valid = 1; iss_rd = 30;
        #1 chk("iss30_first", 64'(iss_ready), 64'd1);
        step();
        #1 chk("iss30_second_stall", 64'(iss_ready), 64'd0);
        req0_valid = 1; req0_rd = 30; req0_data = 32'h30;
        push(30, 32'h30);
        step();
        req0_valid = 0;
        #1 chk("iss30_stall_in_le", 64'(iss_ready), 64'd0);
        step();
        iss_valid = 0;
        #1 chk("iss30_released", 64'(iss_ready), 64'd1);

        // Same-edge set and clear of r31 (write to a non-pending register)
        req0_valid = 1; req0_rd = 31; req0_data = 32'h31;
        push(31, 32'h31);
        step();
        req0_valid = 0;
        iss_valid = 1; iss_rd = 31;
        #1 chk("iss31_ready_in_le", 64'(iss_ready), 64'd1);
        step();
        iss_valid = 0;
        #1 chk("pending31_set_wins", 64'(pending[31]), 64'd1);

        // Bypass window on r7
        iss_valid = 1; iss_rd = 7;
        step();
        iss_valid = 0;
        req0_valid = 1; req0_rd = 7; req0_data = 32'hABCD;
        push(7, 32'hABCD);
        ra = 7; rb = 7; rc = 7;
        step();
        req0_valid = 0;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_fwd_hit", 64'(fwd_hit), 64'b111);
        chk("byp_fwd_data", 64'(fwd_data), 64'hABCD);
        chk("byp_haz", {haz_c, haz_b, haz_a}, 64'b000);
`else
        chk("nobyp_fwd_hit", 64'(fwd_hit), 64'b000);
        chk("nobyp_fwd_data", 64'(fwd_data), 64'd0);
        chk("nobyp_haz", {haz_c, haz_b, haz_a}, 64'b111);
`endif
        step();
        #1 chk("r7_haz_done", {haz_c, haz_b, haz_a}, 64'b000);
        ra = 0; rb = 0; rc = 0;
        step(); step();
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
